input_layer_mac: RTL and testbench
==================================

// Module: input_layer_mac
// PURPOSE
//  Downstream consumer of the 1-bit x 1024 input-pattern RAM: on start, sweeps
//  every input address, reads the pixel bit (1-cycle registered-read RAM) and the
//  matching signed weight (weight ROM with identical read latency), and accumulates
//  the weights of all set pixels into one signed pre-activation sum for a hidden
//  neuron. Result is held, with a done pulse, for the hidden-layer stage.
// PARAMETERS
//  ADDR_W    10    width of ram_addr (input RAM/weight ROM address)
//  N_INPUTS  1024  number of inputs swept, addresses 0..N_INPUTS-1 (<= 2**ADDR_W)
//  WEIGHT_W  8     signed weight width (two's complement)
//  ACC_W     18    signed accumulator/result width
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         one clock; reset is asynchronous and active-low
//  start      in   1         request a sweep; sampled only in IDLE
//  ram_addr   out  ADDR_W    address to input RAM and weight ROM (shared)
//  ram_q      in   1         pixel bit, valid the cycle after ram_addr is sampled
//  weight_q   in   WEIGHT_W  signed weight, same timing as ram_q
//  busy       out  1         high from start acceptance until done pulse ends
//  done       out  1         1-cycle pulse: acc_out valid
//  acc_out    out  ACC_W     signed sum; held from done until next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ram_addr=0, busy=0, done=0, acc_out=0,
//   accumulator=0, pipeline valid flag=0. Reset mid-sweep aborts; no done issued.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//  IDLE: start=1 at edge E0 -> RUN; accumulator cleared, ram_addr=0, busy=1.
//  RUN: ram_addr increments by 1 each edge; after ram_addr=N_INPUTS-1 is driven
//   for one cycle -> DRAIN (ram_addr returns to 0). Address k driven after E_k.
//  Read pipeline: a valid flag tracks each issued address; data for address k is
//   consumed at edge E_(k+2): if valid && ram_q==1, acc <= sat(acc + sext(weight_q));
//   if ram_q==0 acc unchanged. weight_q ignored when ram_q==0 or valid==0.
//  DRAIN: one cycle; consumes data for the last address (N_INPUTS-1) -> DONE.
//  DONE: acc_out <= final acc, done=1 for exactly one cycle -> IDLE; busy drops
//   with the transition to IDLE. done is high in the cycle after E_(N_INPUTS+1).
//  Latency: start edge to done high = N_INPUTS+1 edges (1025 for default).
//  Arithmetic: weight sign-extended to ACC_W; add saturates to
//   [-2**(ACC_W-1), 2**(ACC_W-1)-1], no wrap. Defaults cannot overflow.
//  start while busy (RUN/DRAIN/DONE): ignored, no restart, no queueing.
//  start held high continuously: new sweep accepted on the first IDLE cycle.
//  acc_out changes only in DONE or reset; never shows partial sums.
//  Block never writes the RAM; input RAM write port must be idle during a sweep.
// TESTING
//  1 All RAM bits 0, weights random -> done at start+1025 edges, acc_out=0.
//  2 All bits 1, all weights +1 -> acc_out=1024; all weights -128 -> -131072.
//  3 Only addr 1023 set, weight[1023]=-5, others 1 -> acc_out=-5 (last element
//    consumed in DRAIN); only addr 0 set, weight[0]=7 -> acc_out=7.
//  4 start pulsed again at cycles 10 and 500 of a sweep -> ignored; single done;
//    result identical to undisturbed run; busy stays 1 throughout.
//  5 rst_n low at cycle 300 of sweep -> busy=0, done=0, acc_out=0, ram_addr=0
//    immediately; new start afterwards gives correct full sum.
//  6 N_INPUTS=4, ACC_W=8, all bits 1, weights 127 -> acc_out=127 (saturated);
//    weights -128 -> acc_out=-128; done at start+5 edges.

Source files
------------

// File: rtl/input_layer_mac.sv
// Input-layer MAC: sweeps the pixel RAM and weight ROM once per start and
// accumulates the weights of set pixels into one saturated signed sum.
module input_layer_mac #(
    parameter int ADDR_W   = 10,
    parameter int N_INPUTS = 1024,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [ADDR_W-1:0]          ram_addr,
    input  logic                       ram_q,
    input  logic signed [WEIGHT_W-1:0] weight_q,
    output logic                       busy,
    output logic                       done,
    output logic signed [ACC_W-1:0]    acc_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);

    state_t                    state_q;
    logic [ADDR_W-1:0]         addr_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      vld_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_out_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic        [ACC_W:0]     sum;

    always_comb begin
        sum   = {acc_q[ACC_W-1], acc_q}
              + {{(ACC_W + 1 - WEIGHT_W){weight_q[WEIGHT_W-1]}}, weight_q};
        acc_d = acc_q;
        if (vld_q && ram_q) begin
            // Top two bits disagree only when the add left the ACC_W range.
            if (sum[ACC_W] != sum[ACC_W-1])
                acc_d = {sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}};
            else
                acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            acc_q     <= '0;
            acc_out_q <= '0;
        end else begin
            vld_q  <= (state_q == RUN);
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        acc_q   <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (addr_q == LAST) begin
                        addr_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last product lands here, so the result is visible in DONE.
                    acc_q     <= acc_d;
                    acc_out_q <= acc_d;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign acc_out  = acc_out_q;

endmodule

// File: tb/tb_input_layer_mac.sv
// Bench for input_layer_mac: default-size sweep plus a tiny N_INPUTS=4,
// ACC_W=8 instance for saturation, both checked against a summing model.
module tb_input_layer_mac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              startA = 1'b0;
    logic [9:0]        addrA;
    logic              qA = 1'b0;
    logic signed [7:0] wqA = '0;
    logic              busyA, doneA;
    logic signed [17:0] accA;

    logic              startB = 1'b0;
    logic [1:0]        addrB;
    logic              qB = 1'b0;
    logic signed [7:0] wqB = '0;
    logic              busyB, doneB;
    logic signed [7:0] accB;

    bit                pixA [1024];
    logic signed [7:0] wA   [1024];
    bit                pixB [4];
    logic signed [7:0] wB   [4];

    int n_chk = 0;
    int n_fail = 0;

    input_layer_mac dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .ram_addr(addrA),
        .ram_q(qA), .weight_q(wqA), .busy(busyA), .done(doneA),
        .acc_out(accA)
    );

    input_layer_mac #(.ADDR_W(2), .N_INPUTS(4), .WEIGHT_W(8), .ACC_W(8)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .ram_addr(addrB),
        .ram_q(qB), .weight_q(wqB), .busy(busyB), .done(doneB),
        .acc_out(accB)
    );

    // Registered-read RAM / ROM models
    always @(posedge clk) begin
        qA  <= pixA[addrA];
        wqA <= wA[addrA];
        qB  <= pixB[addrB];
        wqB <= wB[addrB];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int refsum(input bit isA);
        int n, hi, lo, s;
        n  = isA ? 1024 : 4;
        hi = isA ? 131071 : 127;
        lo = -hi - 1;
        s  = 0;
        for (int i = 0; i < n; i++) begin
            if (isA ? pixA[i] : pixB[i]) begin
                s += isA ? int'(wA[i]) : int'(wB[i]);
                if (s > hi) s = hi;
                if (s < lo) s = lo;
            end
        end
        return s;
    endfunction

    task automatic fillA(input int mode, input int wval);
        for (int i = 0; i < 1024; i++) begin
            pixA[i] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom);
            wA[i]   = (wval == 999) ? 8'($urandom) : 8'(wval);
        end
    endtask

    task automatic sweepA(input string tag, input bit disturb);
        int n, exp;
        bit busy_ok;
        exp = refsum(1'b1);
        @(negedge clk); startA = 1'b1;
        @(posedge clk);
        @(negedge clk); startA = 1'b0;
        n = 0;
        busy_ok = busyA;
        while (!doneA && n < 1100) begin
            @(posedge clk); n++;
            @(negedge clk);
            startA = disturb && (n == 10 || n == 500);
            if (!busyA) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, n, 1025);
        chk({tag, "_acc"}, int'(accA), exp);
        chk({tag, "_busy"}, int'(busy_ok), 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'({doneA, busyA}), 0);
        chk({tag, "_acc_held"}, int'(accA), exp);
    endtask

    task automatic sweepB(input string tag);
        int n, exp;
        exp = refsum(1'b0);
        @(negedge clk); startB = 1'b1;
        @(posedge clk);
        @(negedge clk); startB = 1'b0;
        n = 0;
        while (!doneB && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_acc"}, int'(accB), exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(doneB), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busyA), 0);
        chk("rst_done", int'(doneA), 0);
        chk("rst_acc", int'(accA), 0);
        chk("rst_addr", int'(addrA), 0);
        rst_n = 1'b1;

        fillA(0, 999);
        sweepA("allzero", 1'b0);

        fillA(1, 1);
        sweepA("ones_p1", 1'b0);
        chk("ones_p1_const", int'(accA), 1024);
        fillA(1, -128);
        sweepA("ones_m128", 1'b0);
        chk("ones_m128_const", int'(accA), -131072);

        fillA(0, 1);
        pixA[1023] = 1'b1; wA[1023] = -8'sd5;
        sweepA("last_only", 1'b0);
        fillA(0, 1);
        pixA[0] = 1'b1; wA[0] = 8'sd7;
        sweepA("first_only", 1'b0);

        for (int r = 0; r < 2; r++) begin
            fillA(2, 999);
            sweepA("random", 1'b0);
        end

        fillA(2, 999);
        sweepA("disturb", 1'b1);

        // Abort mid-sweep with async reset, then re-run
        fillA(2, 999);
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        repeat (299) @(negedge clk);
        chk("pre_abort_busy", int'(busyA), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", int'({busyA, doneA, addrA}), 0);
        chk("abort_acc", int'(accA), 0);
        @(negedge clk); rst_n = 1'b1;
        sweepA("post_rst", 1'b0);

        for (int i = 0; i < 4; i++) begin pixB[i] = 1'b1; wB[i] = 8'sd127; end
        sweepB("sat_hi");
        chk("sat_hi_const", int'(accB), 127);
        for (int i = 0; i < 4; i++) wB[i] = -8'sd128;
        sweepB("sat_lo");
        chk("sat_lo_const", int'(accB), -128);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                pixB[i] = 1'($urandom);
                wB[i]   = 8'($urandom);
            end
            sweepB("small_rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
